// File: rtl/controller_ram_cpu_port.sv
// CPU-side front end of the controller dual-port RAM (port A): turns native valid/ready bus
// requests inside a 64 KB window into registered RAM port-A cycles and returns read data.
module controller_ram_cpu_port #(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        sel,
  output logic [13:0] ram_addr,
  output logic [31:0] ram_d,
  output logic        ram_we,
  output logic [3:0]  ram_bytesel,
  input  logic [31:0] ram_q,
  output logic [2:0]  dbg_state
);

  // Handshake: a request is accepted only in IDLE while sel=1; mem_ready is a one-cycle pulse and
  // the CPU may keep mem_valid high through the following GAP cycle without starting a new access.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_WAIT = 3'd2,
    ACK     = 3'd3,
    GAP     = 3'd4
  } state_t;

  // One extra wait cycle beyond the RAM latency because ram_addr itself is registered.
  localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY + 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        ready_nxt, we_nxt;
  logic [31:0] rdata_nxt, d_nxt;
  logic [13:0] addr_nxt;
  logic [3:0]  bsel_nxt;
  logic        is_write;
  logic        unused_addr_lsb;

  assign sel             = mem_valid && (mem_addr[31:16] == BASE_ADDR[31:16]);
  assign is_write        = |mem_wstrb;
  assign dbg_state       = state;
  assign unused_addr_lsb = &{1'b0, mem_addr[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      mem_ready   <= 1'b0;
      mem_rdata   <= 32'h0;
      ram_addr    <= 14'h0;
      ram_d       <= 32'h0;
      ram_we      <= 1'b0;
      ram_bytesel <= 4'h0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      mem_ready   <= ready_nxt;
      mem_rdata   <= rdata_nxt;
      ram_addr    <= addr_nxt;
      ram_d       <= d_nxt;
      ram_we      <= we_nxt;
      ram_bytesel <= bsel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel) state_nxt = is_write ? WRITE : RD_WAIT;
      WRITE:   state_nxt = GAP;
      RD_WAIT: if (cnt == 3'd1) state_nxt = ACK;
      ACK:     state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt   = cnt;
    ready_nxt = 1'b0;
    we_nxt    = 1'b0;
    rdata_nxt = mem_rdata;
    addr_nxt  = ram_addr;
    d_nxt     = ram_d;
    bsel_nxt  = ram_bytesel;
    case (state)
      IDLE: begin
        if (sel) begin
          addr_nxt = mem_addr[15:2];
          d_nxt    = mem_wdata;
          bsel_nxt = is_write ? mem_wstrb : 4'hF;
          if (is_write) begin
            we_nxt    = 1'b1;
            ready_nxt = 1'b1;
          end else begin
            cnt_nxt = CNT_LOAD;
          end
        end
      end
      RD_WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) begin
          rdata_nxt = ram_q;
          ready_nxt = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
